xy_symbol_conditioner: RTL
==========================

# xy_symbol_conditioner

Input conditioner sitting directly upstream of the two-input `{x,y}` state machine. It synchronises and debounces two raw asynchronous button lines and turns each confirmed press into a single-cycle symbol on `x` or `y`. The downstream FSM therefore sees clean, mutually exclusive `{x,y}` codes: `2'b10`, `2'b01`, or idle `2'b00`. Conflicting or too-closely-spaced presses are flagged and counted instead of being forwarded.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronised cycles a new level must persist before it is accepted (≥1).
- `MIN_GAP`, default 2: idle cycles enforced after each emitted symbol before another may be emitted (≥0).
- `DROP_W`, default 8: width of the saturating drop counter.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-low.
- `btn_x_raw`  in  1  raw, asynchronous, bouncing button for symbol X.
- `btn_y_raw`  in  1  raw, asynchronous, bouncing button for symbol Y.
- `x`  out  1  one-cycle pulse, X symbol; feeds the FSM `x` input.
- `y`  out  1  one-cycle pulse, Y symbol; feeds the FSM `y` input.
- `sym_valid`  out  1  equals `x|y`.
- `conflict`  out  1  one-cycle pulse when X and Y presses confirm on the same edge.
- `drop_count`  out  `DROP_W`  saturating count of presses discarded by conflict or gap lockout.

## Operation
- **Per-channel front end:**
  - Two-flop synchroniser, then a debounce counter against the registered `stable` level.
  - The counter clears whenever the synchronised level equals `stable`.
  - Otherwise the counter increments. When it would reach `DEBOUNCE_CYCLES`, `stable` flips and the counter clears.
- **Press event:** a `stable` transition 0→1. Releases (1→0) are debounced identically but never emit anything.
- **Arbiter FSM, states `IDLE`, `EMIT`, `GAP`:**
  - `IDLE`, single press event → register the symbol onto `x` or `y` and go to `EMIT`.
  - `IDLE`, both press events on the same edge → pulse `conflict`, increment `drop_count`, stay in `IDLE`; no symbol.
  - `EMIT` lasts exactly one cycle, then goes to `GAP` (or straight to `IDLE` if `MIN_GAP=0`).
  - `GAP` counts `MIN_GAP` cycles, then returns to `IDLE`.
  - Any press event during `EMIT` or `GAP` is discarded and increments `drop_count` (by 2 if both channels fire together). `conflict` is not asserted here.
- `drop_count` saturates at all-ones; it never wraps.
- `x` and `y` are never high together.

## Timing
- **Reset values:** `x=0`, `y=0`, `sym_valid=0`, `conflict=0`, `drop_count=0`; synchroniser flops, `stable` and counters all 0; FSM in `IDLE`.
- **Reset release with a button already held:** `stable` starts at 0, so a held button produces one press event after the normal debounce latency.
- **Latency:** raw rises before edge k and stays high → sync output high after edge k+1 → `stable` rises and `x`/`y` asserts after edge k+1+`DEBOUNCE_CYCLES`. The pulse is high for exactly one cycle.
- **Bounce filtering:** a glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles produces no event and does not change `stable`.
- **Symbol spacing:** minimum spacing between two emitted symbols is 1+`MIN_GAP` cycles of idle output between pulses.
- **Reset asserted mid-operation:** all outputs clear asynchronously and any pending debounce progress is lost.

## Structure
- Shared package `xy_pkg` holds:
  - arbiter state typedef (`IDLE`, `EMIT`, `GAP`);
  - symbol constants `SYM_NONE=2'b00`, `SYM_X=2'b10`, `SYM_Y=2'b01`, used by both this block and the FSM.
- Sub-module `debounce_sync`, instantiated twice: synchroniser, debounce counter, `stable` level, and a one-cycle `press` output.
- Top level contains the arbiter FSM, gap counter and drop counter.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`, `MIN_GAP=2`.
- **Reset:** `rst=0` for 20 ns with buttons toggling → all outputs 0. After release with both buttons low → outputs stay 0.
- **Clean X press:** `btn_x_raw` rises before edge k and holds 10 cycles → `x=1` only in the cycle after edge k+5; `y=0` throughout; `drop_count=0`.
- **Bounce:** `btn_y_raw` high 2 cycles, low 1, high 3, low → no `y` pulse. A subsequent 6-cycle-high press → exactly one `y` pulse.
- **Conflict:** both buttons rise on the same cycle and hold → `conflict` pulses once, `x=y=0`, `drop_count=1`.
- **Gap lockout:** X press emitted, then Y press confirming 1 cycle after the `x` pulse → no `y` pulse, `drop_count` +1. A Y press confirming 3+ cycles after the pulse → `y` pulses.
- **Saturation and mid-operation reset:** force 260 drops with `DROP_W=8` → `drop_count=255` holds. Assert `rst` low mid-debounce → outputs 0 immediately, and the interrupted press is never emitted.

Source files
------------

// File: rtl/xy_pkg.sv
// Shared definitions for the {x,y} symbol path.
// Holds the arbiter state encoding and the two-bit symbol codes that both the
// conditioner and the downstream {x,y} state machine agree on.
// No ports.
package xy_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EMIT = 2'd1,
      GAP  = 2'd2
   } arb_state_t;

   // Symbol codes as seen on {x,y}
   localparam logic [1:0] SYM_NONE = 2'b00;
   localparam logic [1:0] SYM_X    = 2'b10;
   localparam logic [1:0] SYM_Y    = 2'b01;

endpackage

// File: rtl/debounce_sync.sv
// Single-channel button front end: two-flop synchroniser followed by a
// debounce counter that qualifies level changes against a registered stable
// level.
// Ports:
//   clk      system clock
//   rst      asynchronous active-low reset
//   btn_raw  raw asynchronous, bouncing button line
//   press    high in the cycle whose closing edge turns stable from 0 to 1
module debounce_sync #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          meta_reg;
   logic          sync_reg;
   logic          stable_reg;
   logic          stable_next;
   logic [CW-1:0] count_reg;
   logic [CW-1:0] count_next;
   logic          flip;

   // flip is the "counter would reach DEBOUNCE_CYCLES" condition; it is
   // exported (rising only) as press so the arbiter can register the symbol
   // on the same edge that stable changes.
   always_comb begin
      flip        = (sync_reg != stable_reg) &&
                    (count_reg == CW'(DEBOUNCE_CYCLES - 1));
      stable_next = flip ? ~stable_reg : stable_reg;
      if ((sync_reg == stable_reg) || flip) begin
         count_next = '0;
      end else begin
         count_next = count_reg + 1'b1;
      end
      press = flip && sync_reg;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta_reg   <= 1'b0;
         sync_reg   <= 1'b0;
         stable_reg <= 1'b0;
         count_reg  <= '0;
      end else begin
         meta_reg   <= btn_raw;
         sync_reg   <= meta_reg;
         stable_reg <= stable_next;
         count_reg  <= count_next;
      end
   end

endmodule

// File: rtl/xy_symbol_conditioner.sv
// Conditions two raw buttons into clean, mutually exclusive one-cycle {x,y}
// symbols for the downstream state machine. Simultaneous presses raise
// conflict; presses arriving during a symbol or its gap are dropped. Both
// cases are tallied in a saturating counter.
// Ports:
//   clk         system clock
//   rst         asynchronous active-low reset
//   btn_x_raw   raw button for symbol X
//   btn_y_raw   raw button for symbol Y
//   x, y        one-cycle symbol pulses, never high together
//   sym_valid   x | y
//   conflict    one-cycle pulse when both presses confirm together in IDLE
//   drop_count  saturating count of discarded presses
module xy_symbol_conditioner
   import xy_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int MIN_GAP         = 2,
   parameter int DROP_W          = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              btn_x_raw,
   input  logic              btn_y_raw,
   output logic              x,
   output logic              y,
   output logic              sym_valid,
   output logic              conflict,
   output logic [DROP_W-1:0] drop_count
);

   localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

   logic              press_x;
   logic              press_y;
   arb_state_t        state_reg;
   arb_state_t        state_next;
   logic [GW-1:0]     gap_reg;
   logic [GW-1:0]     gap_next;
   logic [1:0]        sym_reg;
   logic [1:0]        sym_next;
   logic              conflict_reg;
   logic              conflict_next;
   logic [DROP_W-1:0] drop_reg;
   logic [DROP_W-1:0] drop_next;
   logic [1:0]        drop_inc;
   logic [DROP_W:0]   drop_sum;

   debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_x (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn_x_raw),
      .press   (press_x)
   );

   debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_y (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn_y_raw),
      .press   (press_y)
   );

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         gap_reg   <= '0;
         sym_reg   <= SYM_NONE;
      end else begin
         state_reg <= state_next;
         gap_reg   <= gap_next;
         sym_reg   <= sym_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      gap_next   = gap_reg;
      sym_next   = sym_reg;
      case (state_reg)
         IDLE: begin
            if (press_x ^ press_y) begin
               state_next = EMIT;
               sym_next   = press_x ? SYM_X : SYM_Y;
            end
         end
         EMIT: begin
            gap_next   = '0;
            state_next = (MIN_GAP == 0) ? IDLE : GAP;
         end
         GAP: begin
            if (gap_reg == GW'(MIN_GAP - 1)) begin
               state_next = IDLE;
            end else begin
               gap_next = gap_reg + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Output logic: symbols decode from registered state only; conflict and
   // drop counting are evaluated here and registered below.
   always_comb begin
      x         = (state_reg == EMIT) && (sym_reg == SYM_X);
      y         = (state_reg == EMIT) && (sym_reg == SYM_Y);
      sym_valid = x | y;
      conflict  = conflict_reg;
      drop_count = drop_reg;

      if (state_reg == IDLE) begin
         conflict_next = press_x && press_y;
         drop_inc      = {1'b0, press_x && press_y};
      end else begin
         conflict_next = 1'b0;
         drop_inc      = {1'b0, press_x} + {1'b0, press_y};
      end

      // One spare bit catches overflow so the counter clamps at all-ones.
      drop_sum  = {1'b0, drop_reg} + {{(DROP_W - 1){1'b0}}, drop_inc};
      drop_next = drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         conflict_reg <= 1'b0;
         drop_reg     <= '0;
      end else begin
         conflict_reg <= conflict_next;
         drop_reg     <= drop_next;
      end
   end

endmodule
